// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  localparam int AWIDTH      = 16;
  localparam int DWIDTH      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int NUM_BLOCKS  = 64;

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = AWIDTH - 1 - OFF_W - IDX_W;
  localparam int CNT_W = OFF_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BLOCK = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic logic [OFF_W-1:0] addr_off(input logic [AWIDTH-1:0] a);
    return a[OFF_W:1];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AWIDTH-1:0] a);
    return a[OFF_W+IDX_W:OFF_W+1];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [AWIDTH-1:0] a);
    return a[AWIDTH-1:OFF_W+IDX_W+1];
  endfunction

  function automatic logic [AWIDTH-1:0] block_base(input logic [AWIDTH-1:0] a);
    return {addr_tag(a), addr_idx(a), {OFF_W{1'b0}}, 1'b0};
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and data storage: combinational read by index/offset, word-wise
// synchronous data write and a separate tag/valid write.
module icache_line_array
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DWIDTH-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              tag_wr_en,
  input  logic [IDX_W-1:0]  tag_wr_idx,
  input  logic [TAG_W-1:0]  tag_wr_tag
);

  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [DWIDTH-1:0]     data_mem [NUM_BLOCKS*BLOCK_WORDS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] valid_d;

  // Next valid vector: a tag write marks its line present.
  always_comb begin
    valid_d = valid_q;
    if (tag_wr_en) begin
      valid_d[tag_wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only reset state; reset wins over a same-cycle tag write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {NUM_BLOCKS{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays are plain RAM, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_idx, wr_off}] <= wr_data;
    end
    if (tag_wr_en) begin
      tag_mem[tag_wr_idx] <= tag_wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, in-order
// whole-block fill on a miss, saturating miss counter.
module icache_dm
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic              cpu_rd_en,
  output logic [DWIDTH-1:0] cpu_instr,
  output logic              miss_stall,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              mem_data_vld,
  output logic [15:0]       miss_count
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;

  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [DWIDTH-1:0] rd_data_s;
  logic              wr_en_s;
  logic              tag_wr_en_s;
  logic              hit_s;

  icache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (addr_idx(cpu_addr)),
    .rd_off     (addr_off(cpu_addr)),
    .rd_valid   (rd_valid_s),
    .rd_tag     (rd_tag_s),
    .rd_data    (rd_data_s),
    .wr_en      (wr_en_s),
    .wr_idx     (addr_idx(base_q)),
    .wr_off     (rsp_cnt_q[OFF_W-1:0]),
    .wr_data    (mem_data),
    .tag_wr_en  (tag_wr_en_s),
    .tag_wr_idx (addr_idx(base_q)),
    .tag_wr_tag (addr_tag(base_q))
  );

  assign hit_s      = (state_q == IDLE) & rd_valid_s & (rd_tag_s == addr_tag(cpu_addr));
  assign miss_stall = cpu_rd_en & ~hit_s;
  assign cpu_instr  = hit_s ? rd_data_s : {DWIDTH{1'b0}};
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign miss_count = miss_count_q;

  // Fill FSM: the request stream runs ahead of, and independently from, the response count.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    miss_count_d = miss_count_q;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    wr_en_s      = 1'b0;
    tag_wr_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_rd_en && !hit_s) begin
          state_d     = FILL;
          base_d      = block_base(cpu_addr);
          mem_rd_en_d = 1'b1;
          mem_addr_d  = block_base(cpu_addr);
          req_cnt_d   = CNT_ONE;
          rsp_cnt_d   = CNT_ZERO;
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end else begin
            miss_count_d = miss_count_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (req_cnt_q < CNT_BLOCK) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + (AWIDTH'(req_cnt_q) << 1);
          req_cnt_d   = req_cnt_q + CNT_ONE;
        end else begin
          mem_rd_en_d = 1'b0;
        end
        if (mem_data_vld && (rsp_cnt_q < CNT_BLOCK)) begin
          wr_en_s   = 1'b1;
          rsp_cnt_d = rsp_cnt_q + CNT_ONE;
          if (rsp_cnt_q == CNT_LAST) begin
            tag_wr_en_s = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= {AWIDTH{1'b0}};
      req_cnt_q    <= CNT_ZERO;
      rsp_cnt_q    <= CNT_ZERO;
      miss_count_q <= 16'h0000;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= {AWIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      miss_count_q <= miss_count_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule
